// File: rtl/seg_scan_mux_pkg.sv
// Shared constants, types and the leading-zero blanking helper for the digit scanner.
package seg_pkg;

  localparam int unsigned NIB_W          = 4;
  localparam int unsigned MAX_DIGITS     = 8;
  localparam int unsigned MAX_IDX_W      = 3;
  localparam int unsigned DEF_NUM_DIGITS = 4;
  localparam int unsigned DEF_SCAN_DIV   = 100000;
  localparam int unsigned DEF_GUARD      = 2;

  typedef logic [NIB_W-1:0]            nib_t;
  typedef logic [MAX_DIGITS*NIB_W-1:0] disp_vec_t;
  typedef logic [MAX_DIGITS-1:0]       dig_vec_t;

  // Per-digit blank vector. Callers zero-extend narrower displays, so padding digits
  // count as leading zeros and never stop a real digit from blanking.
  function automatic dig_vec_t lz_mask(disp_vec_t disp, logic blank_lz, dig_vec_t dp);
    dig_vec_t mask;
    logic     zero_above;
    logic     nib_zero;
    mask       = '0;
    zero_above = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
      nib_zero = (disp[k*NIB_W +: NIB_W] == '0);
      // Digit 0 always shows; a set decimal point keeps a digit lit.
      if (k != 0) begin
        mask[k] = blank_lz & zero_above & nib_zero & ~dp[k];
      end
      zero_above = zero_above & nib_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_mux_scan_tick.sv
// Slot prescaler: counts clk cycles inside one digit slot and flags the slot end and
// the anti-ghosting guard window at the start of each slot.
module scan_tick
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = DEF_SCAN_DIV,
  parameter int unsigned GUARD    = DEF_GUARD,
  localparam int unsigned CntW    = $clog2(SCAN_DIV)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [CntW-1:0] cnt_o,
  output logic            slot_end_o,
  output logic            guard_active_o
);

  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Wrap at the last cycle of the slot.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
    end
  end

  // Slot cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o          = cnt_q;
  assign slot_end_o     = (cnt_q == CntMax);
  assign guard_active_o = (cnt_q < GuardCnt);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex digit scanner feeding a seven-segment decoder. A loaded value is
// parked in a shadow register and only moves to the displayed copy at a frame boundary,
// so a frame never mixes old and new digits.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int unsigned SCAN_DIV   = DEF_SCAN_DIV,
  parameter int unsigned GUARD      = DEF_GUARD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_i,
  input  logic [NIB_W*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]       dp_in_i,
  input  logic                        blank_lz_i,
  output logic [NIB_W-1:0]            digit_nib_o,
  output logic                        dp_out_o,
  output logic [NUM_DIGITS-1:0]       an_o,
  output logic                        blank_o,
  output logic                        frame_start_o
);

  localparam int unsigned     IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned     CntW   = $clog2(SCAN_DIV);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][NIB_W-1:0] digits_t;

  logic [CntW-1:0] cnt;
  logic            slot_end;
  logic            guard_active;
  logic            frame_end;

  logic [IdxW-1:0]       idx_q, idx_d;
  digits_t               shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  digits_t               disp_q, disp_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;

  logic [NIB_W-1:0]      nib_q, nib_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  blank_q, blank_d;
  logic                  fs_q, fs_d;

  disp_vec_t            disp_ext;
  dig_vec_t             dp_ext;
  dig_vec_t             lz_full;
  logic [MAX_IDX_W-1:0] idx_ext;

  scan_tick #(
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) u_scan_tick (
    .clk            (clk),
    .rst_n          (rst_n),
    .cnt_o          (cnt),
    .slot_end_o     (slot_end),
    .guard_active_o (guard_active)
  );

  assign frame_end = slot_end & (idx_q == IdxMax);

  // Advance the digit index once per slot.
  always_comb begin
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow capture and frame-boundary transfer; a load on the boundary itself bypasses
  // the shadow so it is not delayed by a whole frame.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    if (frame_end) begin
      if (load_i) begin
        disp_d    = value_i;
        disp_dp_d = dp_in_i;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
      end
      pending_d = 1'b0;
    end else if (load_i) begin
      shadow_d    = value_i;
      shadow_dp_d = dp_in_i;
      pending_d   = 1'b1;
    end
  end

  // Next output values from the current slot state.
  always_comb begin
    disp_ext                         = '0;
    disp_ext[NIB_W*NUM_DIGITS-1:0]   = disp_q;
    dp_ext                           = '0;
    dp_ext[NUM_DIGITS-1:0]           = disp_dp_q;
    lz_full                          = lz_mask(disp_ext, blank_lz_i, dp_ext);
    idx_ext                          = MAX_IDX_W'(idx_q);
    nib_d                            = disp_q[idx_q];
    dp_d                             = disp_dp_q[idx_q];
    an_d                             = '0;
    // The nibble is driven even while the anode is off so it is settled before lighting.
    if (!guard_active && !lz_full[idx_ext]) begin
      an_d[idx_q] = 1'b1;
    end
    blank_d = (an_d == '0);
    fs_d    = (idx_q == '0) && (cnt == '0);
  end

  // Scan state, value registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pending_q   <= 1'b0;
      nib_q       <= '0;
      dp_q        <= 1'b0;
      an_q        <= '0;
      blank_q     <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pending_q   <= pending_d;
      nib_q       <= nib_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      blank_q     <= blank_d;
      fs_q        <= fs_d;
    end
  end

  assign digit_nib_o   = nib_q;
  assign dp_out_o      = dp_q;
  assign an_o          = an_q;
  assign blank_o       = blank_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised and directed bench for seg_scan_mux with a frame-position reference model.
module tb_seg_scan_mux;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = ND * SD;
  localparam logic [10:0] RESET_V = 11'b0000_0_0000_1_0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] value_i = '0;
  logic [3:0]  dp_in_i = '0;
  logic        blank_lz_i = 1'b0;
  logic [3:0]  digit_nib_o;
  logic        dp_out_o;
  logic [3:0]  an_o;
  logic        blank_o;
  logic        frame_start_o;

  logic [10:0] obs;
  logic [10:0] exp_v;
  int total = 0;
  int bad = 0;
  int n = 0;

  // Reference state: displayed value, parked value, pending flag.
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_dp, m_sdp;
  logic        m_pend;

  assign obs = {digit_nib_o, dp_out_o, an_o, blank_o, frame_start_o};

  seg_scan_mux #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .GUARD      (GD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load_i),
    .value_i       (value_i),
    .dp_in_i       (dp_in_i),
    .blank_lz_i    (blank_lz_i),
    .digit_nib_o   (digit_nib_o),
    .dp_out_o      (dp_out_o),
    .an_o          (an_o),
    .blank_o       (blank_o),
    .frame_start_o (frame_start_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog n=%0d", n);
    $fatal(1);
  end

  task automatic model_clear();
    m_disp = '0; m_shadow = '0; m_dp = '0; m_sdp = '0; m_pend = 1'b0; n = 0;
  endtask

  // One clock with the given inputs; exp_v is what the outputs must show afterwards.
  // n counts edges since reset release, so n % FRAME is the scan position being sampled.
  task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] d,
                      input logic blz);
    int pos, slot, c, hi;
    logic [3:0] an_e;
    logic lit;
    load_i = ld; value_i = v; dp_in_i = d; blank_lz_i = blz;
    pos  = n % FRAME;
    slot = pos / SD;
    c    = pos % SD;
    hi   = 0;
    for (int k = 0; k < ND; k++) if (m_disp[4*k +: 4] != 4'h0) hi = k;
    lit  = (c >= GD) && !(blz && slot > hi && !m_dp[slot]);
    an_e = lit ? (4'b0001 << slot) : 4'b0000;
    exp_v = {m_disp[4*slot +: 4], m_dp[slot], an_e, !lit, pos == 0};
    if (pos == FRAME - 1) begin
      if (ld) begin
        m_disp = v; m_dp = d;
      end else if (m_pend) begin
        m_disp = m_shadow; m_dp = m_sdp;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_shadow = v; m_sdp = d; m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    n++;
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== RESET_V) begin
      bad++; $display("FAIL reset_values got=%b exp=%b", obs, RESET_V);
    end
    model_clear();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b0, 16'h0, 4'h0, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL reset_scan n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_load_mid();
    while (n % FRAME != 12) begin
      tick(1'b0, 16'h0, 4'h0, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL load_pre n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
    tick(1'b1, 16'h12A4, 4'b0010, 1'b0);
    while (n % FRAME != 11) begin
      tick(1'b0, 16'h0, 4'h0, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL load_mid n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
    // Sampled position 10 of the new frame: slot 1, first lit cycle.
    total++;
    if (obs !== 11'b1010_1_0010_0_0) begin
      bad++; $display("FAIL load_slot1 got=%b exp=%b", obs, 11'b1010_1_0010_0_0);
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 16'h0, 4'h0, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL load_post n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_blank_lz();
    int hi_lit, three_lit, lit, zero_lit;
    tick(1'b1, 16'h0030, 4'h0, 1'b1);
    for (int i = 0; i < 70; i++) begin
      tick(1'b0, 16'h0, 4'h0, 1'b1);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL lz_30 n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
    hi_lit = 0; three_lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 16'h0, 4'h0, 1'b1);
      if (an_o[3:2] != 2'b00) hi_lit++;
      if (an_o == 4'b0010 && digit_nib_o == 4'h3) three_lit++;
    end
    total++;
    if (hi_lit !== 0 || three_lit !== SD - GD) begin
      bad++; $display("FAIL lz_30_count hi=%0d three=%0d exp 0 %0d", hi_lit, three_lit, SD - GD);
    end
    tick(1'b1, 16'h0000, 4'h0, 1'b1);
    for (int i = 0; i < 70; i++) begin
      tick(1'b0, 16'h0, 4'h0, 1'b1);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL lz_zero n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
    lit = 0; zero_lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 16'h0, 4'h0, 1'b1);
      if (an_o != 4'b0000) lit++;
      if (an_o == 4'b0001 && digit_nib_o == 4'h0) zero_lit++;
    end
    total++;
    if (lit !== SD - GD || zero_lit !== SD - GD) begin
      bad++; $display("FAIL lz_zero_count lit=%0d d0=%0d exp %0d", lit, zero_lit, SD - GD);
    end
  endtask

  task automatic test_back_to_back();
    int wrong, lit;
    logic [15:0] bv;
    logic [3:0]  e_nib;
    logic        e_dp;
    while (n % FRAME != 3) tick(1'b0, 16'h0, 4'h0, 1'b0);
    tick(1'b1, 16'h1111, 4'h0, 1'b0);
    tick(1'b0, 16'h0, 4'h0, 1'b0);
    tick(1'b1, 16'h2222, 4'h0, 1'b0);
    wrong = 0; lit = 0;
    for (int i = 0; i < 2 * FRAME - 6; i++) begin
      tick(1'b0, 16'h0, 4'h0, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL b2b n=%0d got=%b exp=%b", n, obs, exp_v);
      end
      if (i >= FRAME - 6 && an_o != 4'b0000) begin
        lit++;
        if (digit_nib_o != 4'h2) wrong++;
      end
    end
    total++;
    if (wrong !== 0 || lit !== ND * (SD - GD)) begin
      bad++; $display("FAIL b2b_last_wins wrong=%0d lit=%0d exp 0 %0d", wrong, lit, ND * (SD - GD));
    end
    // Pending value is overridden by a load landing exactly on the boundary.
    while (n % FRAME != 10) tick(1'b0, 16'h0, 4'h0, 1'b0);
    tick(1'b1, 16'h7777, 4'b1111, 1'b0);
    while (n % FRAME != FRAME - 1) tick(1'b0, 16'h0, 4'h0, 1'b0);
    bv = 16'h5A5A;
    tick(1'b1, bv, 4'b0101, 1'b0);
    wrong = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 16'h0, 4'h0, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL bypass n=%0d got=%b exp=%b", n, obs, exp_v);
      end
      e_nib = bv[4*(i / SD) +: 4];
      e_dp  = ((i / SD) % 2) == 0;
      if (digit_nib_o != e_nib || dp_out_o != e_dp) wrong++;
    end
    total++;
    if (wrong !== 0) begin
      bad++; $display("FAIL bypass_frame wrong=%0d exp 0", wrong);
    end
  endtask

  task automatic test_frame();
    int pulses, misplaced, guard_viol, p;
    pulses = 0; misplaced = 0; guard_viol = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b0, 16'h0, 4'h0, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL frame n=%0d got=%b exp=%b", n, obs, exp_v);
      end
      p = (n - 1) % FRAME;
      if (frame_start_o) pulses++;
      if (frame_start_o != (p == 0)) misplaced++;
      if ((p % SD) < GD && an_o != 4'b0000) guard_viol++;
    end
    total++;
    if (pulses !== 2 || misplaced !== 0 || guard_viol !== 0) begin
      bad++; $display("FAIL frame_pulse pulses=%0d misplaced=%0d guard=%0d exp 2 0 0",
                      pulses, misplaced, guard_viol);
    end
  endtask

  task automatic test_random();
    logic        ld, blz;
    logic [15:0] v, msk;
    blz = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (i % 16 == 0) blz = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 4))
        0: msk = 16'hFFFF;
        1: msk = 16'h0FFF;
        2: msk = 16'h00FF;
        3: msk = 16'h000F;
        default: msk = 16'h0000;
      endcase
      v = 16'($urandom) & msk;
      tick(ld, v, 4'($urandom), blz);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL random n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b1, 16'hFFFF, 4'h0, 1'b0);
    while (n % FRAME != 0) tick(1'b0, 16'h0, 4'h0, 1'b0);
    while (n % FRAME != 19) tick(1'b0, 16'h0, 4'h0, 1'b0);
    total++;
    if (digit_nib_o !== 4'hF) begin
      bad++; $display("FAIL pre_reset_nib got=%h exp=f", digit_nib_o);
    end
    rst_n = 1'b0;
    #2;
    total++;
    if (obs !== RESET_V) begin
      bad++; $display("FAIL async_reset got=%b exp=%b", obs, RESET_V);
    end
    @(posedge clk);
    #1;
    total++;
    if (obs !== RESET_V) begin
      bad++; $display("FAIL reset_hold got=%b exp=%b", obs, RESET_V);
    end
    model_clear();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 16'h0, 4'h0, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL post_reset n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load_mid();
    test_blank_lz();
    test_back_to_back();
    test_frame();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
